// File: rtl/fp_decode_stage.sv
// fp_decode_stage: registered RV32F/RV64D decode stage sitting between
// instruction issue and the FPU.
//
// Each accepted instruction is decoded into an FPU command bundle and stored
// in a 2-entry skid buffer. Entry 0 is always the presented command. An
// illegal encoding is still stored and presented, flagged by illegal_o, with
// every write/move/memory enable cleared.
//
// Ports
//   clk_i, rst_ni          clock, async active-low reset
//   flush_i                drop every buffered entry (synchronous)
//   instr_valid_i/_ready_o instruction handshake (ready from registered state)
//   instr_i, tag_i, frm_i  raw instruction, opaque tag, fcsr.frm
//   dec_valid_o/_ready_i   command handshake towards the FPU
//   rs1_o..rd_o            register specifiers
//   op_o, op_mod_o         FPU operation and modifier
//   src_fmt_o, dst_fmt_o   FP32 (0) / FP64 (1)
//   rnd_mode_o             resolved rounding mode
//   fp_we_o, int_we_o      destination register file enables
//   load_o, store_o        FP loads / stores
//   move_xs_o, move_sx_o   FP->int and int->FP bit moves
//   illegal_o              illegal instruction marker
//   tag_o                  tag of the presented command
module fp_decode_stage #(
  parameter bit RVD   = 1'b1,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [2:0]       frm_i,
  output logic             dec_valid_o,
  input  logic             dec_ready_i,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [4:0]       rs3_o,
  output logic [4:0]       rd_o,
  output logic [3:0]       op_o,
  output logic             op_mod_o,
  output logic [2:0]       src_fmt_o,
  output logic [2:0]       dst_fmt_o,
  output logic [2:0]       rnd_mode_o,
  output logic             fp_we_o,
  output logic             int_we_o,
  output logic             load_o,
  output logic             store_o,
  output logic             move_xs_o,
  output logic             move_sx_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam logic [6:0] OPC_LOAD_FP  = 7'h07;
  localparam logic [6:0] OPC_STORE_FP = 7'h27;
  localparam logic [6:0] OPC_MADD     = 7'h43;
  localparam logic [6:0] OPC_MSUB     = 7'h47;
  localparam logic [6:0] OPC_NMSUB    = 7'h4B;
  localparam logic [6:0] OPC_NMADD    = 7'h4F;
  localparam logic [6:0] OPC_OP_FP    = 7'h53;

  // fpnew operation encodings
  localparam logic [3:0] OP_FMADD = 4'd0,  OP_FNMSUB = 4'd1,  OP_ADD  = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3,  OP_DIV    = 4'd4,  OP_SQRT = 4'd5;
  localparam logic [3:0] OP_SGNJ  = 4'd6,  OP_MINMAX = 4'd7,  OP_CMP  = 4'd8;
  localparam logic [3:0] OP_CLASS = 4'd9,  OP_F2F    = 4'd10, OP_F2I  = 4'd11;
  localparam logic [3:0] OP_I2F   = 4'd12;

  typedef struct packed {
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rs3;
    logic [4:0]       rd;
    logic [3:0]       op;
    logic             op_mod;
    logic [2:0]       src_fmt;
    logic [2:0]       dst_fmt;
    logic [2:0]       rnd_mode;
    logic             fp_we;
    logic             int_we;
    logic             load;
    logic             store;
    logic             move_xs;
    logic             move_sx;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  function automatic cmd_t decode(input logic [31:0]      ins,
                                  input logic [2:0]       frm,
                                  input logic [TAG_W-1:0] tag);
    cmd_t       c;
    logic [4:0] rs2;
    logic [2:0] rm;
    logic [2:0] rrm;
    logic       fmt_ok;
    logic       uses_rm;
    logic       ok;
    c       = '0;
    c.rs1   = ins[19:15];
    c.rs2   = ins[24:20];
    c.rs3   = ins[31:27];
    c.rd    = ins[11:7];
    c.tag   = tag;
    rs2     = ins[24:20];
    rm      = ins[14:12];
    rrm     = (rm == 3'b111) ? frm : rm;
    // 111 can only survive resolution on entries that end up illegal
    c.rnd_mode = (rrm == 3'b111) ? 3'b000 : rrm;
    fmt_ok  = (ins[26:25] == 2'b00) || (RVD && (ins[26:25] == 2'b01));
    c.src_fmt = {1'b0, ins[26:25]};
    c.dst_fmt = {1'b0, ins[26:25]};
    uses_rm = 1'b0;
    ok      = 1'b0;
    case (ins[6:0])
      OPC_LOAD_FP, OPC_STORE_FP: begin
        // funct3 is the access width here, not a rounding mode
        ok        = (rm == 3'b010) || (RVD && (rm == 3'b011));
        c.src_fmt = (rm == 3'b011) ? 3'd1 : 3'd0;
        c.dst_fmt = c.src_fmt;
        c.load    = (ins[6:0] == OPC_LOAD_FP);
        c.store   = (ins[6:0] == OPC_STORE_FP);
        c.fp_we   = c.load;
      end
      OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: begin
        // opcode bit 3 picks the negated family, bit 2 the subtracting variant
        c.op     = ins[3] ? OP_FNMSUB : OP_FMADD;
        c.op_mod = ins[2];
        c.fp_we  = 1'b1;
        uses_rm  = 1'b1;
        ok       = fmt_ok;
      end
      OPC_OP_FP: begin
        case (ins[31:27])
          5'b00000, 5'b00001: begin
            c.op = OP_ADD; c.op_mod = ins[27]; c.fp_we = 1'b1; uses_rm = 1'b1; ok = fmt_ok;
          end
          5'b00010: begin c.op = OP_MUL; c.fp_we = 1'b1; uses_rm = 1'b1; ok = fmt_ok; end
          5'b00011: begin c.op = OP_DIV; c.fp_we = 1'b1; uses_rm = 1'b1; ok = fmt_ok; end
          5'b01011: begin
            c.op = OP_SQRT; c.fp_we = 1'b1; uses_rm = 1'b1; ok = fmt_ok && (rs2 == 5'd0);
          end
          5'b00100: begin c.op = OP_SGNJ;   c.fp_we  = 1'b1; ok = fmt_ok && (rm < 3'd3); end
          5'b00101: begin c.op = OP_MINMAX; c.fp_we  = 1'b1; ok = fmt_ok && (rm < 3'd2); end
          5'b10100: begin c.op = OP_CMP;    c.int_we = 1'b1; ok = fmt_ok && (rm < 3'd3); end
          5'b11000: begin
            c.op = OP_F2I; c.op_mod = rs2[0]; c.int_we = 1'b1; uses_rm = 1'b1;
            ok = fmt_ok && (rs2[4:1] == 4'd0);
          end
          5'b11010: begin
            c.op = OP_I2F; c.op_mod = rs2[0]; c.fp_we = 1'b1; uses_rm = 1'b1;
            ok = fmt_ok && (rs2[4:1] == 4'd0);
          end
          5'b01000: begin
            // source format lives in rs2; a same-format conversion is not an instruction
            c.op = OP_F2F; c.fp_we = 1'b1; uses_rm = 1'b1;
            c.src_fmt = {1'b0, rs2[1:0]};
            ok = fmt_ok && (rs2[4:1] == 4'd0) && (!rs2[0] || RVD) && (rs2[1:0] != ins[26:25]);
          end
          5'b11100: begin
            if (rs2 == 5'd0 && rm == 3'b000) begin
              c.op = OP_SGNJ; c.move_xs = 1'b1; c.int_we = 1'b1; ok = fmt_ok;
            end else if (rs2 == 5'd0 && rm == 3'b001) begin
              c.op = OP_CLASS; c.int_we = 1'b1; ok = fmt_ok;
            end
          end
          5'b11110: begin
            if (rs2 == 5'd0 && rm == 3'b000) begin
              c.op = OP_SGNJ; c.move_sx = 1'b1; c.fp_we = 1'b1; ok = fmt_ok;
            end
          end
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    if (!(ok && (!uses_rm || (rrm < 3'b101)))) begin
      c.illegal = 1'b1;
      c.fp_we   = 1'b0;
      c.int_we  = 1'b0;
      c.load    = 1'b0;
      c.store   = 1'b0;
      c.move_xs = 1'b0;
      c.move_sx = 1'b0;
    end
    return c;
  endfunction

  state_e state_q, state_d;
  cmd_t   e0_q, e0_d, e1_q, e1_d;
  cmd_t   new_c;
  logic   acc, pop;

  assign new_c         = decode(instr_i, frm_i, tag_i);
  assign instr_ready_o = (state_q != TWO);
  assign dec_valid_o   = (state_q != EMPTY);
  assign acc           = instr_valid_i & instr_ready_o;
  assign pop           = dec_valid_o & dec_ready_i;

  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (acc) begin e0_d = new_c; state_d = ONE; end
        ONE: begin
          if (acc && pop) begin
            e0_d = new_c;
          end else if (acc) begin
            e1_d = new_c; state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin e0_d = e1_q; state_d = ONE; end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Stage boundary: skid buffer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  assign rs1_o      = e0_q.rs1;
  assign rs2_o      = e0_q.rs2;
  assign rs3_o      = e0_q.rs3;
  assign rd_o       = e0_q.rd;
  assign op_o       = e0_q.op;
  assign op_mod_o   = e0_q.op_mod;
  assign src_fmt_o  = e0_q.src_fmt;
  assign dst_fmt_o  = e0_q.dst_fmt;
  assign rnd_mode_o = e0_q.rnd_mode;
  assign fp_we_o    = e0_q.fp_we;
  assign int_we_o   = e0_q.int_we;
  assign load_o     = e0_q.load;
  assign store_o    = e0_q.store;
  assign move_xs_o  = e0_q.move_xs;
  assign move_sx_o  = e0_q.move_sx;
  assign illegal_o  = e0_q.illegal;
  assign tag_o      = e0_q.tag;

endmodule
